// File: rtl/uart_char_receiver_if.sv
// Interface between the UART RX pin and the display character path.
// The master drives the serial line; the slave is the receiver.
interface uart_char_receiver_if;
    logic       i_RX_Serial;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_Frame_Err;
    logic [7:0] o_Char;

    modport master (
        output i_RX_Serial,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_Frame_Err,
        input  o_Char
    );

    modport slave (
        input  i_RX_Serial,
        output o_RX_DV,
        output o_RX_Byte,
        output o_Frame_Err,
        output o_Char
    );
endinterface

// File: rtl/uart_char_receiver.sv
// 8N1 UART receiver that also keeps the last printable byte as a display character.
// All outputs are registered; a held-low line after a bad stop bit reports one error.
module uart_char_receiver #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    uart_char_receiver_if.slave   rx_if
);
    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]  TERM = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4,
        S_BREAK   = 3'd5
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    logic          sync1_q, rx_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          dv_q, dv_d;
    logic          ferr_q, ferr_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    char_q, char_d;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_if.i_RX_Serial;
            rx_s_q  <= sync1_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            byte_q  <= 8'h00;
            char_q  <= 8'h20;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
            byte_q  <= byte_d;
            char_q  <= char_d;
        end
    end

    // Next-state and output logic; sample points sit at bit centres.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;
        byte_d  = byte_q;
        char_d  = char_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = {CW{1'b0}};
                idx_d = 3'd0;
                if (!rx_s_q) state_d = S_START;
                else         state_d = S_IDLE;
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = {CW{1'b0}};
                    // A line that is high again at mid start bit was only a glitch.
                    if (!rx_s_q) state_d = S_DATA;
                    else         state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == TERM) begin
                    cnt_d          = {CW{1'b0}};
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == TERM) begin
                    cnt_d = {CW{1'b0}};
                    if (rx_s_q) begin
                        dv_d    = 1'b1;
                        byte_d  = shift_q;
                        if (is_printable(shift_q)) char_d = shift_q;
                        else                       char_d = char_q;
                        state_d = S_CLEANUP;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CLEANUP: begin
                state_d = S_IDLE;
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
                else        state_d = S_BREAK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_if.o_RX_DV     = dv_q;
    assign rx_if.o_Frame_Err = ferr_q;
    assign rx_if.o_RX_Byte   = byte_q;
    assign rx_if.o_Char      = char_q;
endmodule

// File: tb/tb_uart_char_receiver.sv
// Directed bench for uart_char_receiver at 8 clocks per bit.
module tb_uart_char_receiver;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   dv_cnt   = 0;
    int   ferr_cnt = 0;
    int   both_cnt = 0;
    int   dv_t_last = 0;
    int   dv_t_prev = 0;

    uart_char_receiver_if u_if ();

    uart_char_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .rx_if   (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.o_RX_DV) begin
            dv_cnt    <= dv_cnt + 1;
            dv_t_prev <= dv_t_last;
            dv_t_last <= cyc;
        end
        if (u_if.o_Frame_Err) ferr_cnt <= ferr_cnt + 1;
        if (u_if.o_RX_DV && u_if.o_Frame_Err) both_cnt <= both_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_byte;
        logic [7:0] exp_char;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        u_if.i_RX_Serial = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        u_if.i_RX_Serial = 1'b1;
    endtask

    task automatic idle(input int n);
        u_if.i_RX_Serial = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] eb, input logic [7:0] ec);
        @(negedge clk);
        check({tag, ".byte"}, {24'd0, u_if.o_RX_Byte}, {24'd0, eb});
        check({tag, ".char"}, {24'd0, u_if.o_Char}, {24'd0, ec});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dv0, fe0;
        vecs[0] = '{data: 8'h4E, exp_byte: 8'h4E, exp_char: 8'h4E};
        vecs[1] = '{data: 8'h0D, exp_byte: 8'h0D, exp_char: 8'h4E};
        vecs[2] = '{data: 8'h20, exp_byte: 8'h20, exp_char: 8'h20};
        vecs[3] = '{data: 8'h7F, exp_byte: 8'h7F, exp_char: 8'h20};
        vecs[4] = '{data: 8'h7E, exp_byte: 8'h7E, exp_char: 8'h7E};
        vecs[5] = '{data: 8'h1F, exp_byte: 8'h1F, exp_char: 8'h7E};

        u_if.i_RX_Serial = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset.dv",   {31'd0, u_if.o_RX_DV},     32'd0);
        check("reset.ferr", {31'd0, u_if.o_Frame_Err}, 32'd0);
        check("reset.byte", {24'd0, u_if.o_RX_Byte},   32'h00);
        check("reset.char", {24'd0, u_if.o_Char},      32'h20);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        for (int i = 0; i < 6; i++) begin
            dv0 = dv_cnt;
            fe0 = ferr_cnt;
            send_frame(vecs[i].data, 1'b1);
            idle(10);
            check($sformatf("vec%0d.dv", i),   dv_cnt - dv0,   32'd1);
            check($sformatf("vec%0d.ferr", i), ferr_cnt - fe0, 32'd0);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_byte, vecs[i].exp_char);
        end

        // Back-to-back frames with no idle gap.
        dv0 = dv_cnt;
        send_frame(8'h6E, 1'b1);
        send_frame(8'h41, 1'b1);
        idle(10);
        check("b2b.dv", dv_cnt - dv0, 32'd2);
        check("b2b.spacing", dv_t_last - dv_t_prev, 32'd80);
        check_outputs("b2b", 8'h41, 8'h41);

        // Bad stop bit followed by a long break.
        dv0 = dv_cnt;
        fe0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        u_if.i_RX_Serial = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(10);
        check("break.ferr", ferr_cnt - fe0, 32'd1);
        check("break.dv",   dv_cnt - dv0,   32'd0);
        check_outputs("break", 8'h41, 8'h41);
        send_frame(8'h31, 1'b1);
        idle(10);
        check_outputs("after_break", 8'h31, 8'h31);

        // Short low glitch in IDLE.
        dv0 = dv_cnt;
        fe0 = ferr_cnt;
        u_if.i_RX_Serial = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(20);
        check("glitch.dv",   dv_cnt - dv0,   32'd0);
        check("glitch.ferr", ferr_cnt - fe0, 32'd0);
        send_frame(8'h7E, 1'b1);
        idle(10);
        check("after_glitch.dv", dv_cnt - dv0, 32'd1);
        check_outputs("after_glitch", 8'h7E, 8'h7E);

        // Reset during data bit 4.
        dv0 = dv_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        u_if.i_RX_Serial = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        u_if.i_RX_Serial = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst.dv",   {31'd0, u_if.o_RX_DV},     32'd0);
        check("midrst.ferr", {31'd0, u_if.o_Frame_Err}, 32'd0);
        check("midrst.byte", {24'd0, u_if.o_RX_Byte},   32'h00);
        check("midrst.char", {24'd0, u_if.o_Char},      32'h20);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(100);
        check("midrst.no_dv", dv_cnt - dv0, 32'd0);
        send_frame(8'h4B, 1'b1);
        idle(10);
        check("after_rst.dv", dv_cnt - dv0, 32'd1);
        check_outputs("after_rst", 8'h4B, 8'h4B);

        check("exclusive", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
